// File: rtl/center_pwm_gen_if.sv
// Control and status bundle for center_pwm_gen: run/duty controls in, waveform and duty status out.
interface center_pwm_gen_if #(
  parameter int unsigned WIDTH = 7
) ();
  logic             en;
  logic [WIDTH-1:0] duty;
  logic             duty_load;
  logic             pwm_out;
  logic             period_start;
  logic [WIDTH-1:0] duty_active;
  logic             pending;

  modport master (
    output en, duty, duty_load,
    input  pwm_out, period_start, duty_active, pending
  );

  modport slave (
    input  en, duty, duty_load,
    output pwm_out, period_start, duty_active, pending
  );
endinterface

// File: rtl/center_pwm_gen.sv
// Centre-aligned PWM generator standing in for the joystick comparator path.
// Duty is double-buffered and only takes effect on a period boundary.
module center_pwm_gen #(
  parameter int unsigned WIDTH          = 7,
  parameter int unsigned STEPS          = 100,
  parameter int unsigned TICKS_PER_STEP = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  center_pwm_gen_if.slave   bus
);

  localparam int unsigned PERIOD_TICKS = STEPS * TICKS_PER_STEP;
  localparam int unsigned POS_W        = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int unsigned CMP_W        = POS_W + 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PERIOD_TICKS - 1);
  localparam logic [CMP_W-1:0] PERIOD_C = CMP_W'(PERIOD_TICKS);
  localparam logic [WIDTH-1:0] STEPS_C  = WIDTH'(STEPS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] duty_active_q, duty_active_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic [WIDTH-1:0] duty_sat;
  logic             boundary;
  logic [CMP_W-1:0] on_ticks;
  logic [CMP_W-1:0] half_on;
  logic [CMP_W-1:0] pos_ext;

  always_comb begin
    state_d        = bus.en ? RUN : IDLE;
    pos_d          = '0;
    duty_active_d  = duty_active_q;
    pending_d      = pending_q;
    pend_duty_d    = pend_duty_q;

    if (state_d == RUN && state_q == RUN && pos_q != POS_LAST) begin
      pos_d = pos_q + POS_W'(1);
    end

    // A boundary is any edge landing on pos 0 in RUN, including IDLE->RUN.
    boundary = (state_d == RUN) && (pos_d == '0);
    duty_sat = (bus.duty > STEPS_C) ? STEPS_C : bus.duty;

    if (bus.duty_load) begin
      pend_duty_d = duty_sat;
      pending_d   = 1'b1;
    end

    // A load coinciding with the boundary bypasses the pending register.
    if (boundary) begin
      if (bus.duty_load) begin
        duty_active_d = duty_sat;
      end else if (pending_q) begin
        duty_active_d = pend_duty_q;
      end
      pending_d = 1'b0;
    end

    // Compare against next-state values so pwm_out lines up with pos.
    on_ticks       = CMP_W'(duty_active_d) * CMP_W'(TICKS_PER_STEP);
    half_on        = on_ticks >> 1;
    pos_ext        = CMP_W'(pos_d);
    pwm_d          = (state_d == RUN) &&
                     ((pos_ext < half_on) || (pos_ext >= PERIOD_C - half_on));
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pos_q          <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      pending_q      <= 1'b0;
      duty_active_q  <= '0;
      pend_duty_q    <= '0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      pending_q      <= pending_d;
      duty_active_q  <= duty_active_d;
      pend_duty_q    <= pend_duty_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.duty_active  = duty_active_q;
  assign bus.pending      = pending_q;

endmodule
